// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the MEM-stage load/store initiator:
// memory op encodings, FSM state codes and response error codes.
package lsu_mem_initiator_pkg;

  localparam int MEMOP_W_BITS = 3;
  localparam int ERR_BITS     = 2;

  localparam logic [2:0] MEMOP_W   = 3'b000;
  localparam logic [2:0] MEMOP_H   = 3'b001;
  localparam logic [2:0] MEMOP_B   = 3'b010;
  localparam logic [2:0] MEMOP_LH  = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_LB  = 3'b110;
  localparam logic [2:0] MEMOP_LBU = 3'b111;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational access classifier: alignment against the op width,
// then range against ADDR_LIMIT; misalignment wins when both apply.
module lsu_align_chk
  import lsu_mem_initiator_pkg::*;
#(
  parameter int ADDR_LIMIT = 256
) (
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic [1:0]  err
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned = 1'b0;
    case (op)
      MEMOP_W:                      misaligned = (addr[1:0] != 2'b00);
      MEMOP_H, MEMOP_LH, MEMOP_LHU: misaligned = addr[0];
      default:                      misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (addr >= 32'(ADDR_LIMIT));

  assign err = misaligned   ? ERR_MISALIGN :
               out_of_range ? ERR_RANGE    : ERR_OK;

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: accepts one access, holds the memory port
// for MEM_LAT cycles, then presents one registered response until consumed.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  lsu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             we_reg, we_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic [2:0]       mem_op_reg, mem_op_next;
  logic [31:0]      mem_wdata_reg, mem_wdata_next;
  logic [31:0]      resp_rdata_reg, resp_rdata_next;
  logic [1:0]       resp_err_reg, resp_err_next;

  logic [1:0]       chk_err;
  logic [31:0]      rep_wdata;

  lsu_align_chk #(
    .ADDR_LIMIT(ADDR_LIMIT)
  ) u_align_chk (
    .op  (req_op),
    .addr(req_addr),
    .err (chk_err)
  );

  // Store data is copied onto every lane; the memory's byte enables pick the live one(s).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rep_wdata[8*gi +: 8] =
      (req_op == MEMOP_B) ? req_wdata[7:0] :
      (req_op == MEMOP_H) ? req_wdata[8*(gi % 2) +: 8] :
                            req_wdata[8*gi +: 8];
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    we_next         = we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_op_next     = mem_op_reg;
    mem_wdata_next  = mem_wdata_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          resp_rdata_next = '0;
          resp_err_next   = chk_err;
          // Faulting accesses never touch the memory port.
          if (chk_err != ERR_OK) begin
            state_next = ST_RESP;
          end else begin
            we_next        = req_we;
            mem_addr_next  = req_addr;
            mem_op_next    = req_op;
            mem_wdata_next = rep_wdata;
            cnt_next       = CNT_LOAD;
            state_next     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          if (!we_reg) begin
            resp_rdata_next = mem_rdata;
          end
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      mem_addr_reg   <= '0;
      mem_op_reg     <= '0;
      mem_wdata_reg  <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= ERR_OK;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      we_reg         <= we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_op_reg     <= mem_op_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign busy       = (state_reg == ST_WAIT) || (state_reg == ST_RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_op     = mem_op_reg;
  assign mem_wdata  = mem_wdata_reg;
  // Single write strobe on the last held cycle of a store.
  assign mem_we     = (state_reg == ST_WAIT) && (cnt_reg == '0) && we_reg;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: MEM_LAT=1 instance on a combinational memory and
// MEM_LAT=3 instance on a memory that returns garbage until the port has settled.
module tb_lsu_mem_initiator;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  int          lat = LAT_A;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic [31:0] mem_rdata;

  logic        req_ready_a, resp_valid_a, busy_a, mem_we_a;
  logic        req_ready_b, resp_valid_b, busy_b, mem_we_b;
  logic [31:0] resp_rdata_a, mem_addr_a, mem_wdata_a;
  logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b;
  logic [1:0]  resp_err_a, resp_err_b;
  logic [2:0]  mem_op_a, mem_op_b;

  logic        req_ready, resp_valid, busy, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0]  resp_err;
  logic [2:0]  mem_op;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.MEM_LAT(LAT_A), .ADDR_LIMIT(256)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(req_ready_a),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready && !sel),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .busy(busy_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .mem_op(mem_op_a), .mem_rdata(mem_rdata)
  );

  lsu_mem_initiator #(.MEM_LAT(LAT_B), .ADDR_LIMIT(256)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(req_ready_b),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready && sel),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_op(mem_op_b), .mem_rdata(mem_rdata)
  );

  assign req_ready  = sel ? req_ready_b  : req_ready_a;
  assign resp_valid = sel ? resp_valid_b : resp_valid_a;
  assign busy       = sel ? busy_b       : busy_a;
  assign mem_we     = sel ? mem_we_b     : mem_we_a;
  assign resp_rdata = sel ? resp_rdata_b : resp_rdata_a;
  assign resp_err   = sel ? resp_err_b   : resp_err_a;
  assign mem_addr   = sel ? mem_addr_b   : mem_addr_a;
  assign mem_wdata  = sel ? mem_wdata_b  : mem_wdata_a;
  assign mem_op     = sel ? mem_op_b     : mem_op_a;

  // ---------------- data memory (little-endian words, extends on read) -------
  logic [31:0] dmem [64];
  int          stab = 0;
  logic [34:0] last_ao = '0;
  logic [31:0] dm_w, dm_rd, wr_w;
  logic [15:0] dm_h;
  logic [7:0]  dm_b;

  always @(posedge clk) begin
    if (mem_we) begin
      wr_w = dmem[mem_addr[7:2]];
      case (mem_op)
        3'b000:                wr_w = mem_wdata;
        3'b001, 3'b100, 3'b101: wr_w[16*mem_addr[1] +: 16] = mem_wdata[16*mem_addr[1] +: 16];
        default:               wr_w[8*mem_addr[1:0] +: 8] = mem_wdata[8*mem_addr[1:0] +: 8];
      endcase
      dmem[mem_addr[7:2]] <= wr_w;
    end
    if ({mem_addr, mem_op} != last_ao) begin
      stab    <= 0;
      last_ao <= {mem_addr, mem_op};
    end else begin
      stab <= stab + 1;
    end
  end

  always_comb begin
    dm_w = dmem[mem_addr[7:2]];
    dm_h = dm_w[16*mem_addr[1] +: 16];
    dm_b = dm_w[8*mem_addr[1:0] +: 8];
    case (mem_op)
      3'b000:         dm_rd = dm_w;
      3'b001, 3'b100: dm_rd = {{16{dm_h[15]}}, dm_h};
      3'b101:         dm_rd = {16'h0, dm_h};
      3'b111:         dm_rd = {24'h0, dm_b};
      default:        dm_rd = {{24{dm_b[7]}}, dm_b};
    endcase
    mem_rdata = (sel && stab < LAT_B - 2) ? 32'hDEAD_BEEF : dm_rd;
  end

  // ---------------- checking infrastructure ----------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------------------------------
  byte unsigned ref_mem [256];
  int          cyc = 0;
  bit          pending = 1'b0;
  bit          was_pending;
  int          resp_at, we_at;
  bit          m_store_good;
  logic [1:0]  m_err;
  logic [31:0] m_rdata, m_rep, m_mem_addr = '0, m_req_addr, m_req_wdata;
  logic [2:0]  m_mem_op = '0, m_req_op;
  int          we_pulses = 0;
  logic [31:0] last_we_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int op_bytes(input logic [2:0] op);
    if (op == 3'b000) return 4;
    if (op == 3'b001 || op == 3'b100 || op == 3'b101) return 2;
    return 1;
  endfunction

  function automatic logic [1:0] model_err(input logic [2:0] op, input logic [31:0] a);
    if (op_bytes(op) == 4 && a % 4 != 0) return 2'b01;
    if (op_bytes(op) == 2 && a % 2 != 0) return 2'b01;
    if (a >= 256) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rep(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = (op == 3'b001) ? 2 : (op == 3'b010) ? 1 : 4;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_mem[(a + k) % 256];
    case (op)
      3'b000:  return v;
      3'b100:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'h0, v[15:0]};
      3'b110:  return {{24{v[7]}}, v[7:0]};
      3'b111:  return {24'h0, v[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    = 1'b0;
      m_mem_addr = '0;
      m_mem_op   = '0;
    end else begin
      was_pending = pending;
      if (mem_we) begin
        we_pulses++;
        last_we_wdata = mem_wdata;
      end
      if (was_pending && m_store_good && cyc == we_at)
        for (int k = 0; k < op_bytes(m_req_op); k++)
          ref_mem[(m_req_addr + k) % 256] = m_req_wdata[8*k +: 8];
      if (was_pending && cyc >= resp_at && resp_ready) pending = 1'b0;
      if (!was_pending && req_valid) begin
        m_err        = model_err(req_op, req_addr);
        resp_at      = (m_err != 2'b00) ? cyc + 1 : cyc + 1 + lat;
        we_at        = cyc + lat;
        m_store_good = req_we && (m_err == 2'b00);
        m_rdata      = (!req_we && m_err == 2'b00) ? ref_load(req_op, req_addr) : 32'h0;
        m_req_addr   = req_addr;
        m_req_op     = req_op;
        m_req_wdata  = req_wdata;
        if (m_err == 2'b00) begin
          m_mem_addr = req_addr;
          m_mem_op   = req_op;
          m_rep      = model_rep(req_op, req_wdata);
        end
        pending = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst req_ready", req_ready, 1);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_op", mem_op, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst resp_rdata", resp_rdata, 0);
      chk("rst resp_err", resp_err, 0);
    end else begin
      chk("mem_addr", mem_addr, m_mem_addr);
      chk("mem_op", mem_op, m_mem_op);
      if (!pending) begin
        chk("idle req_ready", req_ready, 1);
        chk("idle busy", busy, 0);
        chk("idle resp_valid", resp_valid, 0);
        chk("idle mem_we", mem_we, 0);
      end else if (cyc < resp_at) begin
        chk("wait req_ready", req_ready, 0);
        chk("wait busy", busy, 1);
        chk("wait resp_valid", resp_valid, 0);
        chk("wait mem_we", mem_we, (m_store_good && cyc == we_at) ? 1 : 0);
        chk("wait mem_wdata", mem_wdata, m_rep);
      end else begin
        chk("resp req_ready", req_ready, 0);
        chk("resp busy", busy, 1);
        chk("resp resp_valid", resp_valid, 1);
        chk("resp mem_we", mem_we, 0);
        chk("resp rdata", resp_rdata, m_rdata);
        chk("resp err", resp_err, m_err);
      end
    end
  end

  // ---------------- directed stimulus ----------------------------------------
  task automatic do_req(input string nm, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic [1:0] exp_er, input int bp);
    int t, k, p0;
    p0 = we_pulses;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, (exp_er != 2'b00) ? 1 : lat + 1);
    if (bp > 0) begin
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = addr + 4;
      repeat (bp) @(negedge clk);
      req_valid = 1'b0;
    end
    chk({nm, " rdata"}, resp_rdata, exp_rd);
    chk({nm, " err"}, resp_err, exp_er);
    chk({nm, " we pulses"}, we_pulses - p0, (we && exp_er == 2'b00) ? 1 : 0);
    $display("txn %s: we=%0d op=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
             nm, we, op, addr, resp_rdata, resp_err, k);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    int p0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_req("SW 0x10",    1'b1, 3'b000, 32'h10,  32'h11223344, 32'h0,        2'b00, 0);
    do_req("LW 0x10",    1'b0, 3'b000, 32'h10,  32'h0,        32'h11223344, 2'b00, 0);
    do_req("SB 0x13",    1'b1, 3'b010, 32'h13,  32'h000000AB, 32'h0,        2'b00, 0);
    chk("SB lane data", last_we_wdata, 32'hABABABAB);
    do_req("LBU 0x13",   1'b0, 3'b111, 32'h13,  32'h0,        32'h000000AB, 2'b00, 0);
    do_req("LB 0x13",    1'b0, 3'b110, 32'h13,  32'h0,        32'hFFFFFFAB, 2'b00, 0);
    do_req("LW 0x10 b",  1'b0, 3'b000, 32'h10,  32'h0,        32'hAB223344, 2'b00, 0);
    chk("mem word 0x10", dmem[4], 32'hAB223344);
    do_req("SH 0x12",    1'b1, 3'b001, 32'h12,  32'h00008001, 32'h0,        2'b00, 0);
    chk("SH lane data", last_we_wdata, 32'h80018001);
    do_req("LH 0x12",    1'b0, 3'b100, 32'h12,  32'h0,        32'hFFFF8001, 2'b00, 0);
    do_req("LHU 0x12",   1'b0, 3'b101, 32'h12,  32'h0,        32'h00008001, 2'b00, 0);
    do_req("LW 0x02",    1'b0, 3'b000, 32'h02,  32'h0,        32'h0,        2'b01, 0);
    do_req("SW 0x100",   1'b1, 3'b000, 32'h100, 32'hFFFFFFFF, 32'h0,        2'b10, 0);
    chk("mem word 0x00", dmem[0], 32'h0);
    do_req("LH 0x101",   1'b0, 3'b100, 32'h101, 32'h0,        32'h0,        2'b01, 0);
    do_req("LW 0x10 bp", 1'b0, 3'b000, 32'h10,  32'h0,        32'h8001_3344, 2'b00, 5);

    // Switch to the MEM_LAT=3 instance across a reset.
    @(negedge clk);
    rst_n = 1'b0;
    sel = 1'b1;
    lat = LAT_B;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_req("B SW 0x40",  1'b1, 3'b000, 32'h40,  32'h55667788, 32'h0,        2'b00, 0);
    do_req("B LW 0x40",  1'b0, 3'b000, 32'h40,  32'h0,        32'h55667788, 2'b00, 0);
    do_req("B LB 0x43",  1'b0, 3'b110, 32'h43,  32'h0,        32'h00000055, 2'b00, 0);
    do_req("B LHU 0x42", 1'b0, 3'b101, 32'h42,  32'h0,        32'h00005566, 2'b00, 0);
    do_req("B SB 0x41",  1'b1, 3'b010, 32'h41,  32'h0000009C, 32'h0,        2'b00, 0);
    do_req("B LB 0x41",  1'b0, 3'b110, 32'h41,  32'h0,        32'hFFFFFF9C, 2'b00, 2);
    do_req("B LW 0x06",  1'b0, 3'b000, 32'h06,  32'h0,        32'h0,        2'b01, 0);

    // Reset during the WAIT phase of a store must abort it cleanly.
    p0 = we_pulses;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort req_ready", req_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort mem_we", mem_we, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort resp_valid", resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort no pulse", we_pulses - p0, 0);
    chk("abort mem word 0x20", dmem[8], 32'h0);
    $display("txn abort SW 0x20: pulses=%0d word=0x%08h", we_pulses - p0, dmem[8]);
    do_req("B LW 0x20",  1'b0, 3'b000, 32'h20,  32'h0,        32'h0,        2'b00, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
